demux_stream: RTL and testbench

Parametrised, registered 1-to-N_CH demultiplexer with valid/ready handshake on the input and on every output channel. It replaces the combinational 1-bit, 2-output demux in streaming datapaths. Packet-aware: the destination is latched on the first beat and held until the last beat, so a packet never splits across channels. Each channel has a one-entry output register, giving 1-cycle latency and full throughput.

---
 rtl/demux_stream.sv | 186 ++++++++++++++++++
 tb/tb_demux_stream.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/demux_stream.sv
// demux_stream: registered, packet-aware 1-to-N_CH stream demultiplexer.
//
// The destination is taken from in_sel on the first beat of a packet and
// held until the beat carrying in_last, so a packet never splits across
// channels. Every channel owns a one-entry output register, which gives
// 1-cycle latency and full throughput. A packet whose first-beat select is
// >= N_CH is accepted and discarded, and err_sel pulses once for it.
//
// Optional build macro: DEMUX_STREAM_STATS_EN adds per-channel completed
// packet counters (pkt_cnt) and a dropped packet counter (drop_cnt). Both
// are 16 bits wide and wrap.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input beat valid
//   in_ready   input beat accepted when in_valid && in_ready
//   in_data    input payload
//   in_sel     destination channel, used on the first beat of a packet only
//   in_last    final beat of a packet
//   out_valid  per-channel valid, bit i = channel i
//   out_ready  per-channel ready
//   out_data   channel i payload at [i*DATA_W +: DATA_W]
//   err_sel    1-cycle pulse when an illegal-select packet is dropped
//   busy       high while a legal multi-beat packet is in progress
//   pkt_cnt    (stats build) channel i count at [i*16 +: 16]
//   drop_cnt   (stats build) dropped packet count
//
// state | meaning
// IDLE  | waiting for the first beat of a packet; route by in_sel
// BURST | inside a legal packet; route by latched select
// DROP  | inside an illegal packet; accept and discard beats

module demux_stream #(
    parameter int DATA_W = 8,
    parameter int N_CH   = 4,
    parameter int SEL_W  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic                     in_last,
    output logic [N_CH-1:0]          out_valid,
    input  logic [N_CH-1:0]          out_ready,
    output logic [N_CH*DATA_W-1:0]   out_data,
    output logic                     err_sel,
`ifdef DEMUX_STREAM_STATS_EN
    output logic [N_CH*16-1:0]       pkt_cnt,
    output logic [15:0]              drop_cnt,
`endif
    output logic                     busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    state_t                        r_state;
    state_t                        w_next;
    logic [SEL_W-1:0]              r_sel;
    logic [N_CH-1:0]               r_valid;
    logic [N_CH-1:0][DATA_W-1:0]   r_data;
    logic                          r_err;

    logic [SEL_W-1:0]              w_eff_sel;
    logic                          w_sel_legal;
    logic                          w_drop;
    logic [N_CH-1:0]               w_dst;
    logic                          w_acc;
    logic                          w_first_drop;

    // Zero-extend before comparing so N_CH == 2**SEL_W does not overflow.
    assign w_sel_legal = (32'(in_sel) < N_CH);

    always_comb begin
        w_eff_sel = in_sel;
        if (r_state == S_BURST) begin
            w_eff_sel = r_sel;
        end
    end

    assign w_drop = (r_state == S_DROP) || ((r_state == S_IDLE) && !w_sel_legal);

    // One-hot destination; all zero while discarding, so an illegal select
    // never indexes past the last channel.
    always_comb begin
        w_dst = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_dst[i] = !w_drop && (w_eff_sel == SEL_W'(i));
        end
    end

    // Only the destination channel gates the input.
    assign in_ready     = w_drop || (|(w_dst & (~r_valid | out_ready)));
    assign w_acc        = in_valid && in_ready;
    assign w_first_drop = w_acc && (r_state == S_IDLE) && !w_sel_legal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_acc && !in_last) begin
                    w_next = w_sel_legal ? S_BURST : S_DROP;
                end
            end
            S_BURST, S_DROP: begin
                if (w_acc && in_last) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_acc && (r_state == S_IDLE)) begin
                r_sel <= in_sel;
            end
            r_err <= w_first_drop;
        end
    end

    // Load wins over drain, so a simultaneous drain and load keeps valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_data  <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (w_acc && w_dst[i]) begin
                    r_valid[i] <= 1'b1;
                    r_data[i]  <= in_data;
                end else if (out_ready[i]) begin
                    r_valid[i] <= 1'b0;
                end
            end
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign err_sel   = r_err;
    assign busy      = (r_state == S_BURST);

`ifdef DEMUX_STREAM_STATS_EN
    logic [N_CH-1:0][15:0] r_pkt_cnt;
    logic [15:0]           r_drop_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pkt_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (w_acc && in_last && w_dst[i]) begin
                    r_pkt_cnt[i] <= r_pkt_cnt[i] + 16'd1;
                end
            end
            if (w_first_drop) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    assign pkt_cnt  = r_pkt_cnt;
    assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_demux_stream.sv
module tb_demux_stream;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic        in_last;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data;
    logic        err_sel;
    logic        busy;

    logic        in_valid3;
    logic        in_ready3;
    logic [7:0]  in_data3;
    logic [1:0]  in_sel3;
    logic        in_last3;
    logic [2:0]  out_valid3;
    logic [2:0]  out_ready3;
    logic [23:0] out_data3;
    logic        err_sel3;
    logic        busy3;

`ifdef DEMUX_STREAM_STATS_EN
    logic [63:0] pkt_cnt;
    logic [15:0] drop_cnt;
    logic [47:0] pkt_cnt3;
    logic [15:0] drop_cnt3;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    demux_stream #(.DATA_W(8), .N_CH(4), .SEL_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .err_sel   (err_sel),
`ifdef DEMUX_STREAM_STATS_EN
        .pkt_cnt   (pkt_cnt),
        .drop_cnt  (drop_cnt),
`endif
        .busy      (busy)
    );

    demux_stream #(.DATA_W(8), .N_CH(3), .SEL_W(2)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .in_data   (in_data3),
        .in_sel    (in_sel3),
        .in_last   (in_last3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .out_data  (out_data3),
        .err_sel   (err_sel3),
`ifdef DEMUX_STREAM_STATS_EN
        .pkt_cnt   (pkt_cnt3),
        .drop_cnt  (drop_cnt3),
`endif
        .busy      (busy3)
    );

    typedef struct {
        logic       v;
        logic [1:0] sel;
        logic [7:0] d;
        logic       last;
        logic [3:0] ordy;
        logic       exp_rdy;
        logic [3:0] exp_ov;
        logic       exp_busy;
        int         ch;
        logic [7:0] exp_d;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] sel, input logic [7:0] d,
                         input logic last, input logic [3:0] ordy);
        in_valid  = v;
        in_sel    = sel;
        in_data   = d;
        in_last   = last;
        out_ready = ordy;
    endtask

    task automatic drive3(input logic v, input logic [1:0] sel, input logic [7:0] d,
                          input logic last);
        in_valid3 = v;
        in_sel3   = sel;
        in_data3  = d;
        in_last3  = last;
    endtask

    initial begin
        //           v  sel d      last ordy  rdy ov       busy ch exp_d
        vecs[0]  = '{1, 2, 8'hA5, 1, 4'hF, 1, 4'b0100, 0, 2, 8'hA5};
        vecs[1]  = '{0, 0, 8'h00, 0, 4'hF, 1, 4'b0000, 0, 2, 8'hA5};
        vecs[2]  = '{1, 1, 8'h11, 0, 4'hF, 1, 4'b0010, 1, 1, 8'h11};
        vecs[3]  = '{1, 3, 8'h22, 0, 4'hF, 1, 4'b0010, 1, 1, 8'h22};
        vecs[4]  = '{1, 3, 8'h33, 1, 4'hF, 1, 4'b0010, 0, 1, 8'h33};
        vecs[5]  = '{0, 0, 8'h00, 0, 4'hF, 1, 4'b0000, 0, 3, 8'h00};
        vecs[6]  = '{1, 0, 8'h40, 1, 4'hE, 1, 4'b0001, 0, 0, 8'h40};
        vecs[7]  = '{1, 0, 8'h41, 1, 4'hE, 0, 4'b0001, 0, 0, 8'h40};
        vecs[8]  = '{1, 2, 8'hC2, 1, 4'hE, 1, 4'b0101, 0, 0, 8'h40};
        vecs[9]  = '{1, 2, 8'hC3, 1, 4'hE, 1, 4'b0101, 0, 2, 8'hC3};
        vecs[10] = '{1, 0, 8'h41, 1, 4'hF, 1, 4'b0001, 0, 0, 8'h41};
        vecs[11] = '{1, 0, 8'h42, 1, 4'hF, 1, 4'b0001, 0, 0, 8'h42};
        vecs[12] = '{0, 0, 8'h00, 0, 4'hF, 1, 4'b0000, 0, 0, 8'h42};

        out_ready3 = 3'b111;
        drive(1'b1, 2'd2, 8'h5A, 1'b1, 4'hF);
        drive3(1'b1, 2'd1, 8'h5A, 1'b1);
        rst_n = 1'b1;
        tick();
        tick();
        // Reset asserted mid-run with traffic present.
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_err_sel", 32'(err_sel), 32'h0);
        chk("rst_out_valid3", 32'(out_valid3), 32'h0);
        tick();
        chk("rst_hold_out_valid", 32'(out_valid), 32'h0);
        drive(1'b0, 2'd0, 8'h00, 1'b0, 4'hF);
        drive3(1'b0, 2'd0, 8'h00, 1'b0);
        #2;
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].v, vecs[i].sel, vecs[i].d, vecs[i].last, vecs[i].ordy);
            #1;
            chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
            tick();
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
            chk($sformatf("vec%0d_ch%0d_data", i, vecs[i].ch),
                32'(out_data[vecs[i].ch*8 +: 8]), 32'(vecs[i].exp_d));
        end

`ifdef DEMUX_STREAM_STATS_EN
        chk("pkt_cnt_ch0", 32'(pkt_cnt[15:0]), 32'd3);
        chk("pkt_cnt_ch1", 32'(pkt_cnt[31:16]), 32'd1);
        chk("pkt_cnt_ch2", 32'(pkt_cnt[47:32]), 32'd3);
        chk("pkt_cnt_ch3", 32'(pkt_cnt[63:48]), 32'd0);
        chk("drop_cnt3_before", 32'(drop_cnt3), 32'd0);
`endif

        // Illegal select on the 3-channel instance: 2-beat packet to sel=3.
        drive3(1'b1, 2'd3, 8'hE1, 1'b0);
        #1;
        chk("ill_b1_in_ready", 32'(in_ready3), 32'h1);
        tick();
        chk("ill_b1_err_sel", 32'(err_sel3), 32'h1);
        chk("ill_b1_out_valid", 32'(out_valid3), 32'h0);
        chk("ill_b1_busy", 32'(busy3), 32'h0);
        drive3(1'b1, 2'd0, 8'hE2, 1'b1);
        #1;
        chk("ill_b2_in_ready", 32'(in_ready3), 32'h1);
        tick();
        chk("ill_b2_err_sel", 32'(err_sel3), 32'h0);
        chk("ill_b2_out_valid", 32'(out_valid3), 32'h0);
        drive3(1'b1, 2'd2, 8'hE3, 1'b1);
        tick();
        chk("ill_after_out_valid", 32'(out_valid3), 32'b100);
        chk("ill_after_data", 32'(out_data3[23:16]), 32'hE3);
        chk("ill_after_err_sel", 32'(err_sel3), 32'h0);
        drive3(1'b0, 2'd0, 8'h00, 1'b0);
`ifdef DEMUX_STREAM_STATS_EN
        chk("drop_cnt3_after", 32'(drop_cnt3), 32'd1);
        chk("pkt_cnt3_ch2", 32'(pkt_cnt3[47:32]), 32'd1);
`endif
        tick();

        // Reset in the middle of a 4-beat packet to ch3, held by backpressure.
        drive(1'b1, 2'd3, 8'h77, 1'b0, 4'h0);
        tick();
        chk("mid_b1_busy", 32'(busy), 32'h1);
        chk("mid_b1_out_valid", 32'(out_valid), 32'b1000);
        drive(1'b0, 2'd0, 8'h00, 1'b0, 4'h0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_out_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_out_data", out_data, 32'h0);
        #2;
        rst_n = 1'b1;
        drive(1'b1, 2'd1, 8'h99, 1'b1, 4'hF);
        tick();
        chk("mid_new_out_valid", 32'(out_valid), 32'b0010);
        chk("mid_new_ch1_data", 32'(out_data[15:8]), 32'h99);
        chk("mid_new_busy", 32'(busy), 32'h0);
        drive(1'b0, 2'd0, 8'h00, 1'b0, 4'hF);
        tick();
        chk("mid_drain_out_valid", 32'(out_valid), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
